// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one instruction-memory read at a time from the current PC,
// tags returned words with their PC and queues them for decode; flush-safe.
module instr_fetch_unit #(
  parameter int N     = 32,
  parameter int IW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_pc,
  output logic          o_en_pc,
  input  logic          i_flush,
  output logic          o_imem_req,
  output logic [N-1:0]  o_imem_addr,
  input  logic          i_imem_gnt,
  input  logic          i_imem_rvalid,
  input  logic [IW-1:0] i_imem_rdata,
  output logic          o_inst_valid,
  output logic [IW-1:0] o_inst,
  output logic [N-1:0]  o_inst_pc,
  input  logic          i_inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e                  state_q, state_d;
  logic [N-1:0]            addr_q, addr_d;
  logic [N-1:0]            tag_q, tag_d;
  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DEPTH-1:0][IW-1:0] data_q, data_d;
  logic [DEPTH-1:0][N-1:0]  pc_q, pc_d;

  logic         push, pop, credit;
  logic [CW:0]  used;
  logic [N-1:0] push_pc, pc_aligned;
  logic         unused_pc_lsbs;

  assign unused_pc_lsbs = ^i_pc[1:0];
  assign pc_aligned     = {i_pc[N-1:2], 2'b00};

  // An in-flight read reserves a FIFO slot, so the queue can never overflow.
  assign used   = {1'b0, cnt_q} + {{CW{1'b0}}, (state_q != IDLE)};
  assign credit = used < (CW+1)'(DEPTH);

  assign o_imem_req   = (state_q == REQ);
  assign o_imem_addr  = addr_q;
  assign o_en_pc      = (o_imem_req && i_imem_gnt) || i_flush;
  assign o_inst_valid = (cnt_q != '0);
  assign o_inst       = data_q[rptr_q];
  assign o_inst_pc    = pc_q[rptr_q];
  assign pop          = o_inst_valid && i_inst_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    push    = 1'b0;
    push_pc = tag_q;
    if (i_flush) begin
      unique case (state_q)
        REQ:     state_d = (i_imem_gnt && !i_imem_rvalid) ? DROP : IDLE;
        WAIT:    state_d = i_imem_rvalid ? IDLE : DROP;
        DROP:    state_d = i_imem_rvalid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: if (credit) begin
          state_d = REQ;
          addr_d  = pc_aligned;
        end
        REQ: if (i_imem_gnt) begin
          tag_d = addr_q;
          if (i_imem_rvalid) begin
            // Zero-wait memory: i_pc only advances at this edge, so the next
            // sequential word is derived from the granted address.
            push    = 1'b1;
            push_pc = addr_q;
            state_d = credit ? REQ : IDLE;
            addr_d  = credit ? addr_q + N'(4) : addr_q;
          end else begin
            state_d = WAIT;
          end
        end
        WAIT: if (i_imem_rvalid) begin
          push    = 1'b1;
          state_d = credit ? REQ : IDLE;
          if (credit) addr_d = pc_aligned;
        end
        DROP: if (i_imem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d = data_q;
    pc_d   = pc_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      data_d[wptr_q] = i_imem_rdata;
      pc_d[wptr_q]   = push_pc;
    end
    if (i_flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      tag_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

endmodule
